// File: rtl/sc_neuron_pkg.sv
// Shared definitions for the time-multiplexed perceptron neuron.
// Holds the FSM state encoding and the accumulator width formula.
package sc_neuron_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAccum   = 2'd1,
    StCompare = 2'd2,
    StDone    = 2'd3
  } state_e;

  // Widest sum is n*(2^dw-1)^2, which always fits in 2*dw + clog2(n) bits.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/sc_neuron_mac_datapath.sv
// Neuron datapath: multiplier, full-width accumulator, pair counter and threshold register.
// Driven by acc_clr / acc_en / thr_ld from the controlling FSM.
module sc_neuron_mac_datapath
  import sc_neuron_pkg::*;
#(
  parameter int unsigned NUMBER_DATAWIDTH = 8,
  parameter int unsigned NUMBER_INPUTS    = 4,
  localparam int unsigned ACC_W = acc_width(NUMBER_DATAWIDTH, NUMBER_INPUTS),
  localparam int unsigned CNT_W = $clog2(NUMBER_INPUTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_acc_clr,
  input  logic                        i_acc_en,
  input  logic                        i_thr_ld,
  input  logic [NUMBER_DATAWIDTH-1:0] i_x,
  input  logic [NUMBER_DATAWIDTH-1:0] i_w,
  input  logic [ACC_W-1:0]            i_t0,
  output logic [ACC_W-1:0]            o_acc,
  output logic [ACC_W-1:0]            o_thr,
  output logic                        o_last_pair
);

  localparam int unsigned PROD_W = 2 * NUMBER_DATAWIDTH;

  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_prod_ext;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_thr;
  logic [CNT_W-1:0]  r_count;

  assign w_prod     = {{NUMBER_DATAWIDTH{1'b0}}, i_x} * {{NUMBER_DATAWIDTH{1'b0}}, i_w};
  assign w_prod_ext = {{(ACC_W - PROD_W){1'b0}}, w_prod};

  // Clear wins over enable so an abort in the same cycle as an accept drops that pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (i_acc_clr) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (i_acc_en) begin
      r_acc   <= r_acc + w_prod_ext;
      r_count <= r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thr <= '0;
    end else if (i_thr_ld) begin
      r_thr <= i_t0;
    end
  end

  assign o_acc       = r_acc;
  assign o_thr       = r_thr;
  assign o_last_pair = (r_count == CNT_W'(NUMBER_INPUTS - 1));

endmodule

// File: rtl/sc_neuron_mac.sv
// Time-multiplexed perceptron neuron: accumulates NUMBER_INPUTS (x,w) pairs from a
// valid/ready stream, compares the sum against a threshold and strobes done.
module sc_neuron_mac
  import sc_neuron_pkg::*;
#(
  parameter int unsigned NUMBER_DATAWIDTH = 8,
  parameter int unsigned NUMBER_INPUTS    = 4,
  localparam int unsigned ACC_W = acc_width(NUMBER_DATAWIDTH, NUMBER_INPUTS)
) (
  input  logic                        SC_NEURON_MAC_CLOCK_50,
  input  logic                        SC_NEURON_MAC_RESET_InLow,
  input  logic                        SC_NEURON_MAC_start_In,
  input  logic                        SC_NEURON_MAC_clear_In,
  input  logic [ACC_W-1:0]            SC_NEURON_MAC_t0_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_NEURON_MAC_x_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_NEURON_MAC_w_InBUS,
  input  logic                        SC_NEURON_MAC_valid_In,
  output logic                        SC_NEURON_MAC_ready_Out,
  output logic                        SC_NEURON_MAC_busy_Out,
  output logic                        SC_NEURON_MAC_done_Out,
  output logic                        SC_NEURON_MAC_y0_Out,
  output logic [ACC_W-1:0]            SC_NEURON_MAC_sum_OutBUS
);

  state_e           r_state;
  state_e           w_state_next;
  logic             w_acc_clr;
  logic             w_acc_en;
  logic             w_thr_ld;
  logic             w_last_pair;
  logic [ACC_W-1:0] w_acc;
  logic [ACC_W-1:0] w_thr;
  logic [ACC_W-1:0] r_sum;
  logic             r_y0;

  sc_neuron_mac_datapath #(
    .NUMBER_DATAWIDTH (NUMBER_DATAWIDTH),
    .NUMBER_INPUTS    (NUMBER_INPUTS)
  ) u_datapath (
    .clk         (SC_NEURON_MAC_CLOCK_50),
    .rst_n       (SC_NEURON_MAC_RESET_InLow),
    .i_acc_clr   (w_acc_clr),
    .i_acc_en    (w_acc_en),
    .i_thr_ld    (w_thr_ld),
    .i_x         (SC_NEURON_MAC_x_InBUS),
    .i_w         (SC_NEURON_MAC_w_InBUS),
    .i_t0        (SC_NEURON_MAC_t0_InBUS),
    .o_acc       (w_acc),
    .o_thr       (w_thr),
    .o_last_pair (w_last_pair)
  );

  always_ff @(posedge SC_NEURON_MAC_CLOCK_50 or negedge SC_NEURON_MAC_RESET_InLow) begin
    if (!SC_NEURON_MAC_RESET_InLow) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_clr    = 1'b0;
    w_acc_en     = 1'b0;
    w_thr_ld     = 1'b0;
    if (SC_NEURON_MAC_clear_In) begin
      // Abort overrides everything, including a start in the same cycle.
      w_state_next = StIdle;
      w_acc_clr    = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (SC_NEURON_MAC_start_In) begin
            w_thr_ld     = 1'b1;
            w_acc_clr    = 1'b1;
            w_state_next = StAccum;
          end
        end
        StAccum: begin
          if (SC_NEURON_MAC_valid_In) begin
            w_acc_en = 1'b1;
            if (w_last_pair) begin
              w_state_next = StCompare;
            end
          end
        end
        StCompare: w_state_next = StDone;
        StDone:    w_state_next = StIdle;
        default:   w_state_next = StIdle;
      endcase
    end
  end

  // Result registers hold the last completed evaluation across aborts.
  always_ff @(posedge SC_NEURON_MAC_CLOCK_50 or negedge SC_NEURON_MAC_RESET_InLow) begin
    if (!SC_NEURON_MAC_RESET_InLow) begin
      r_sum <= '0;
      r_y0  <= 1'b0;
    end else if (!SC_NEURON_MAC_clear_In && (r_state == StCompare)) begin
      r_sum <= w_acc;
      r_y0  <= (w_acc >= w_thr);
    end
  end

  assign SC_NEURON_MAC_ready_Out  = (r_state == StAccum);
  assign SC_NEURON_MAC_busy_Out   = (r_state != StIdle);
  assign SC_NEURON_MAC_done_Out   = (r_state == StDone);
  assign SC_NEURON_MAC_y0_Out     = r_y0;
  assign SC_NEURON_MAC_sum_OutBUS = r_sum;

endmodule

// File: tb/tb_sc_neuron_mac.sv
// Scoreboard bench for sc_neuron_mac: stimulus pushes expected results, a monitor
// pops and compares them whenever done is presented.
module tb_sc_neuron_mac;

  localparam int DW    = 8;
  localparam int N     = 4;
  localparam int ACC_W = 18;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             clear = 1'b0;
  logic [ACC_W-1:0] t0 = '0;
  logic [DW-1:0]    x = '0;
  logic [DW-1:0]    w = '0;
  logic             valid = 1'b0;
  logic             ready;
  logic             busy;
  logic             done;
  logic             y0;
  logic [ACC_W-1:0] sum;

  sc_neuron_mac #(
    .NUMBER_DATAWIDTH (DW),
    .NUMBER_INPUTS    (N)
  ) dut (
    .SC_NEURON_MAC_CLOCK_50    (clk),
    .SC_NEURON_MAC_RESET_InLow (rst_n),
    .SC_NEURON_MAC_start_In    (start),
    .SC_NEURON_MAC_clear_In    (clear),
    .SC_NEURON_MAC_t0_InBUS    (t0),
    .SC_NEURON_MAC_x_InBUS     (x),
    .SC_NEURON_MAC_w_InBUS     (w),
    .SC_NEURON_MAC_valid_In    (valid),
    .SC_NEURON_MAC_ready_Out   (ready),
    .SC_NEURON_MAC_busy_Out    (busy),
    .SC_NEURON_MAC_done_Out    (done),
    .SC_NEURON_MAC_y0_Out      (y0),
    .SC_NEURON_MAC_sum_OutBUS  (sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int y0;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_sum = 0;
  int   last_y0 = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int model_sum(input logic [31:0] xv, input logic [31:0] wv);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(xv[8*i +: 8]) * int'(wv[8*i +: 8]);
    return s;
  endfunction

  // Monitor: every done strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum", int'(sum), e.sum);
        chk("y0", int'(y0), e.y0);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One evaluation: start, N pairs (optional gap and mid-run start pulse), then
  // returns one tick into the DONE cycle.
  task automatic run(input logic [31:0] xv, input logic [31:0] wv, input logic [ACC_W-1:0] thr,
                     input int gap_at, input int gap_len, input int restart_at);
    exp_t e;
    int   gaps;
    gaps = (gap_at >= 0 && gap_at < N) ? gap_len : 0;
    tick();
    start = 1'b1;
    t0    = thr;
    valid = 1'b1;
    x     = DW'($urandom);
    w     = DW'($urandom);
    e.sum = model_sum(xv, wv);
    e.y0  = (e.sum >= int'(thr)) ? 1 : 0;
    e.cyc = cyc + N + 2 + gaps;
    exp_q.push_back(e);
    last_sum = e.sum;
    last_y0  = e.y0;
    tick();
    start = 1'b0;
    t0    = ACC_W'($urandom);
    for (int i = 0; i < N; i++) begin
      if (i == gap_at) begin
        repeat (gap_len) begin
          valid = 1'b0;
          x     = DW'($urandom);
          w     = DW'($urandom);
          tick();
        end
      end
      if (i == restart_at) begin
        start = 1'b1;
        t0    = ~thr;
      end
      valid = 1'b1;
      x     = xv[8*i +: 8];
      w     = wv[8*i +: 8];
      chk("ready_accum", int'(ready), 1);
      tick();
      start = 1'b0;
    end
    // Junk pairs offered in COMPARE and DONE must not be consumed.
    x = DW'($urandom);
    w = DW'($urandom);
    chk("ready_compare", int'(ready), 0);
    chk("busy_compare", int'(busy), 1);
    tick();
    chk("ready_done", int'(ready), 0);
    valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]      rx;
    logic [31:0]      rw;
    logic [ACC_W-1:0] rt;
    int               s;

    #3;
    chk("reset_ready", int'(ready), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_y0", int'(y0), 0);
    chk("reset_sum", int'(sum), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic run and threshold boundary.
    run(32'h04030201, 32'h08070605, 18'd70, -1, 0, -1);
    run(32'h04030201, 32'h08070605, 18'd71, -1, 0, -1);
    // Maximum operands: no wrap.
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 18'd260100, -1, 0, -1);
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 18'd260101, -1, 0, -1);
    // Three-cycle gap between pairs 2 and 3.
    run(32'h04030201, 32'h08070605, 18'd70, 2, 3, -1);
    // Start re-pulsed mid-ACCUM with a threshold that would flip y0.
    run(32'h04030201, 32'h08070605, 18'd70, -1, 0, 1);

    // Start asserted in DONE must not launch a new run.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("idle_after_done", int'(busy), 0);
    tick();
    chk("start_in_done_ignored", int'(busy), 0);

    // Clear beats start in IDLE.
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    chk("clear_beats_start", int'(busy), 0);

    // Abort after two pairs.
    start = 1'b1;
    t0    = 18'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1;
      x     = DW'($urandom);
      w     = DW'($urandom);
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    valid = 1'b0;
    chk("clear_busy", int'(busy), 0);
    chk("clear_ready", int'(ready), 0);
    chk("clear_keeps_sum", int'(sum), last_sum);
    chk("clear_keeps_y0", int'(y0), last_y0);
    repeat (8) tick();
    run(32'h01020304, 32'h05060708, 18'd60, -1, 0, -1);

    // Asynchronous reset mid-ACCUM.
    tick();
    start = 1'b1;
    t0    = 18'd5;
    tick();
    start = 1'b0;
    valid = 1'b1;
    x     = 8'd10;
    w     = 8'd10;
    tick();
    tick();
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    chk("rst_ready", int'(ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_y0", int'(y0), 0);
    chk("rst_sum", int'(sum), 0);
    tick();
    tick();
    chk("rst_held_busy", int'(busy), 0);
    rst_n = 1'b1;
    last_sum = 0;
    last_y0  = 0;
    run(32'h01000000, 32'h03090909, 18'd3, -1, 0, -1);

    // Back-to-back runs: each start is in the cycle after done.
    run(32'h04030201, 32'h08070605, 18'd69, -1, 0, -1);
    tick();
    run(32'h10203040, 32'h01020304, 18'd1000, -1, 0, -1);

    // Randomized runs with random gaps and thresholds near the sum.
    for (int k = 0; k < 24; k++) begin
      rx = $urandom;
      rw = $urandom;
      s  = model_sum(rx, rw);
      case ($urandom_range(0, 2))
        0:       rt = ACC_W'(s);
        1:       rt = ACC_W'(s + 1);
        default: rt = ACC_W'($urandom_range(0, 262143));
      endcase
      run(rx, rw, rt, int'($urandom_range(0, 5)), int'($urandom_range(1, 4)), -1);
      if ($urandom_range(0, 1) == 1) tick();
    end

    repeat (4) tick();
    chk("pending_results", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
